// File: rtl/tone_arb_pkg.sv
// Shared types and helpers for the speaker tone arbiter.
package tone_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/speaker_tone_arbiter_beat_tick_gen.sv
// Beat tick divider: one-cycle tick every DIV clocks, restartable.
module beat_tick_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((DIV > 1) ? DIV - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == LAST)
      cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/speaker_tone_arbiter.sv
// Fixed-priority speaker sharing with beat timing and inter-tone gap.
// Define TONE_PREEMPT_EN to let higher-priority requests abort a tone.
module speaker_tone_arbiter
  import tone_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int PER_W    = 20,
  parameter int BEAT_W   = 4,
  parameter int BEAT_DIV = 25000000,
  parameter int GAP_CYC  = 2000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*PER_W-1:0]    period,
  input  logic [NUM_REQ*BEAT_W-1:0]   beats,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic [owner_w(NUM_REQ)-1:0] owner,
  output logic                        spk_out
);

  localparam int OW = owner_w(NUM_REQ);
  localparam int GW =
    (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST =
    (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  state_e              state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [PER_W-1:0]    hp_q, hp_d;
  logic [BEAT_W-1:0]   rem_q, rem_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                spk_q, spk_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;

  logic                grant;
  logic                tick;
  logic                preempt;
  logic [OW-1:0]       pick;
  logic [PER_W-1:0]    pick_per;
  logic [BEAT_W-1:0]   pick_beats;

  // Lowest index wins: scan downward so it overwrites last.
  always_comb begin
    pick       = '0;
    pick_per   = '0;
    pick_beats = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick       = OW'(i);
        pick_per   = period[i*PER_W +: PER_W];
        pick_beats = beats[i*BEAT_W +: BEAT_W];
      end
    end
  end

  assign grant = (state_q == IDLE) && (|req);

`ifdef TONE_PREEMPT_EN
  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (OW'(i) < owner_q))
        preempt = 1'b1;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  beat_tick_gen #(
    .DIV (BEAT_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    per_d   = per_q;
    hp_d    = hp_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    spk_d   = spk_q;
    ack_d   = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = PLAY;
          owner_d     = pick;
          per_d       = pick_per;
          hp_d        = '0;
          spk_d       = 1'b0;
          ack_d[pick] = 1'b1;
          rem_d       = (pick_beats == '0) ?
                        BEAT_W'(1) : pick_beats;
        end
      end
      PLAY: begin
        if (per_q == '0) begin
          spk_d = 1'b0;
        end else if (hp_q == per_q - PER_W'(1)) begin
          hp_d  = '0;
          spk_d = ~spk_q;
        end else begin
          hp_d = hp_q + PER_W'(1);
        end
        if (tick)
          rem_d = rem_q - BEAT_W'(1);
        // A tone finishing naturally outranks a same-cycle abort.
        if (tick && rem_q == BEAT_W'(1)) begin
          state_d         = GAP;
          gap_d           = '0;
          spk_d           = 1'b0;
          done_d[owner_q] = 1'b1;
        end else if (preempt) begin
          state_d         = IDLE;
          spk_d           = 1'b0;
          done_d[owner_q] = 1'b1;
        end
      end
      GAP: begin
        spk_d = 1'b0;
        if (gap_q == GW'(GAP_LAST))
          state_d = IDLE;
        else
          gap_d = gap_q + GW'(1);
      end
      default: begin
        state_d = IDLE;
        spk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      per_q   <= '0;
      hp_q    <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      spk_q   <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      per_q   <= per_d;
      hp_q    <= hp_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      spk_q   <= spk_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign spk_out = spk_q;

endmodule

// File: tb/tb_speaker_tone_arbiter.sv
// Bench for speaker_tone_arbiter: directed scenarios then random traffic,
// checked every cycle against a timestamp-based tone model.
module tb_speaker_tone_arbiter;

  localparam int N    = 3;
  localparam int PW   = 8;
  localparam int BW   = 4;
  localparam int DIV  = 10;
  localparam int GAPC = 4;
  localparam int GAPN = (GAPC > 0) ? GAPC : 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*PW-1:0] period;
  logic [N*BW-1:0] beats;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic            busy;
  logic [1:0]      owner;
  logic            spk_out;

  int checks = 0;
  int errors = 0;
  int now    = 0;

  bit           m_busy;
  bit           m_gap;
  int           m_own;
  int           m_per;
  int           m_len;
  int           m_t0;
  int           m_gend;
  logic [N-1:0] m_ack;
  logic [N-1:0] m_done;
  logic [N-1:0] hold_m;
  bit           rnd;

  speaker_tone_arbiter #(
    .NUM_REQ  (N),
    .PER_W    (PW),
    .BEAT_W   (BW),
    .BEAT_DIV (DIV),
    .GAP_CYC  (GAPC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .period  (period),
    .beats   (beats),
    .ack     (ack),
    .done    (done),
    .busy    (busy),
    .owner   (owner),
    .spk_out (spk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h",
               tag, now, got, exp);
    end
  endtask

  function automatic logic exp_spk();
    if (!m_busy || m_gap || m_per == 0)
      return 1'b0;
    return (((now - m_t0) / m_per) % 2) == 1;
  endfunction

  task automatic cmp();
    check("ack",   32'(ack),     32'(m_ack));
    check("done",  32'(done),    32'(m_done));
    check("busy",  32'(busy),    32'(m_busy));
    check("owner", 32'(owner),   32'(m_own));
    check("spk",   32'(spk_out), 32'(exp_spk()));
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_gap  = 1'b0;
    m_own  = 0;
    m_per  = 0;
    m_ack  = '0;
    m_done = '0;
  endtask

  // Advance the model across one clock edge using current inputs.
  task automatic model_step();
    int b;
    int j;
    m_ack  = '0;
    m_done = '0;
    if (!m_busy) begin
      if (req != '0) begin
        j = 0;
        while (!req[j]) j++;
        b        = int'(beats[j*BW +: BW]);
        m_own    = j;
        m_per    = int'(period[j*PW +: PW]);
        m_len    = ((b == 0) ? 1 : b) * DIV;
        m_t0     = now + 1;
        m_busy   = 1'b1;
        m_gap    = 1'b0;
        m_ack[j] = 1'b1;
      end
    end else if (!m_gap) begin
      if (now - m_t0 == m_len - 1) begin
        m_done[m_own] = 1'b1;
        m_gap         = 1'b1;
        m_gend        = now + 1 + GAPN;
      end
`ifdef TONE_PREEMPT_EN
      else if ((req & ((3'b001 << m_own) - 3'b001)) != '0) begin
        m_done[m_own] = 1'b1;
        m_busy        = 1'b0;
      end
`endif
    end else if (now + 1 == m_gend) begin
      m_busy = 1'b0;
      m_gap  = 1'b0;
    end
    now++;
  endtask

  task automatic load(input int i);
    period[i*PW +: PW] = PW'($urandom_range(5, 0));
    beats[i*BW +: BW]  = BW'($urandom_range(3, 0));
  endtask

  task automatic set_req(input int i, input int p, input int b);
    req[i]             = 1'b1;
    period[i*PW +: PW] = PW'(p);
    beats[i*BW +: BW]  = BW'(b);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!rnd) begin
        if (ack[i] && !hold_m[i])
          req[i] = 1'b0;
      end else if (ack[i]) begin
        if ($urandom_range(1, 0) == 0)
          req[i] = 1'b0;
        if ($urandom_range(3, 0) == 0)
          load(i);
      end else if (!req[i]) begin
        if ($urandom_range(15, 0) == 0) begin
          req[i] = 1'b1;
          load(i);
        end
      end else if ($urandom_range(199, 0) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  // Starts on a falling edge; model steps just before each rising edge.
  task automatic run(input int n);
    repeat (n) begin
      #4;
      if (rst_n)
        model_step();
      else
        model_reset();
      @(negedge clk);
      cmp();
      drive();
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    req    = '0;
    period = '0;
    beats  = '0;
    hold_m = '0;
    rnd    = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 cmp();
    @(negedge clk);
    cmp();
    run(3);
    rst_n = 1'b1;

    set_req(1, 3, 2);
    run(40);

    set_req(1, 2, 1);
    set_req(2, 4, 2);
    run(70);

    set_req(0, 0, 3);
    run(45);

    set_req(2, 1, 0);
    run(25);

    hold_m = 3'b001;
    set_req(0, 2, 1);
    run(50);
    hold_m = '0;
    run(40);

    hold_m = 3'b010;
    set_req(1, 3, 3);
    run(6);
    rst_n = 1'b0;
    model_reset();
    #1 cmp();
    check("rst_spk",   32'(spk_out), 32'(0));
    check("rst_busy",  32'(busy),    32'(0));
    check("rst_owner", 32'(owner),   32'(0));
    @(negedge clk);
    cmp();
    run(2);
    rst_n = 1'b1;
    run(40);
    hold_m = '0;
    run(80);

    set_req(2, 2, 3);
    run(5);
    set_req(0, 3, 1);
    run(60);

    rnd = 1'b1;
    run(3000);
    req = '0;
    run(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
